data_memory_bytewise: RTL and testbench

//  Parametrised, byte-addressed data memory for the single-cycle RISC-V core.

---
 rtl/data_memory_bytewise.sv | 187 ++++++++++++++++++
 tb/tb_data_memory_bytewise.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_bytewise.sv
// data_memory_bytewise
//   Byte-addressed RV32I data memory: LB/LH/LW/LBU/LHU loads with sign or zero
//   extension, SB/SH/SW stores through byte-lane merges. Loads are combinational.
//   After reset the array is zeroed by a one-word-per-cycle sweep. The busy
//   output stays high until the sweep finishes.
//   The optional macro DMEM_MISALIGN_TRAP_EN blocks misaligned accesses and
//   adds a sticky error flag. Without it, misaligned accesses are forced to an
//   aligned address and still complete.
module data_memory_bytewise #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] read_address,
  input  logic [31:0] Write_data,
  output logic [31:0] MemData_out,
  output logic        busy,
  output logic        access_err
`ifdef DMEM_MISALIGN_TRAP_EN
  ,
  output logic        err_sticky
`endif
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t           state_reg;
  logic             busy_reg;
  logic [IDX_W-1:0] clr_idx_reg;

  logic [31:0] mem [DEPTH_WORDS];

  // Address split. Bits above the index wrap onto the same words.
  logic [IDX_W-1:0] word_idx;
  logic [1:0]       byte_off;
  logic             unused_addr_bits;

  assign word_idx         = read_address[IDX_W+1:2];
  assign byte_off         = read_address[1:0];
  assign unused_addr_bits = ^read_address[31:IDX_W+2];

  // funct3 decode
  logic is_b, is_h, is_w, is_bu, is_hu;
  logic f3_illegal, f3_unsigned, misalign, any_access, trap_block;

  assign is_b        = (funct3 == 3'b000);
  assign is_h        = (funct3 == 3'b001);
  assign is_w        = (funct3 == 3'b010);
  assign is_bu       = (funct3 == 3'b100);
  assign is_hu       = (funct3 == 3'b101);
  assign f3_illegal  = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
  assign f3_unsigned = is_bu | is_hu;
  assign misalign    = ((is_h | is_hu) & byte_off[0]) | (is_w & (byte_off != 2'b00));
  assign any_access  = MemRead | MemWrite;

  // Error reporting does not depend on busy. The core sees it even while stalled.
  assign access_err = (any_access & f3_illegal)
                    | (MemWrite & f3_unsigned)
                    | (any_access & misalign);

`ifdef DMEM_MISALIGN_TRAP_EN
  assign trap_block = misalign;
`else
  assign trap_block = 1'b0;
`endif

  // Store qualification: SBU/SHU do not exist, so they are treated as illegal stores.
  logic store_blocked, store_en, load_ok;

  assign store_blocked = f3_illegal | f3_unsigned | trap_block;
  assign store_en      = MemWrite & ~busy_reg & ~reset & ~store_blocked;
  assign load_ok       = MemRead & ~busy_reg & ~f3_illegal & ~trap_block;

  // Lane view of the addressed word, plus the write-merge datapath
  logic [31:0] rd_word;
  logic [7:0]  rd_lane [4];
  logic [7:0]  wr_lane [4];
  logic [3:0]  lane_mask;
  logic [31:0] merged_word;

  assign rd_word = mem[word_idx];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign rd_lane[gi] = rd_word[8*gi +: 8];
      // Each lane's candidate byte comes from the replicated byte, half or full word.
      assign wr_lane[gi] = is_b ? Write_data[7:0]
                         : is_h ? Write_data[8*(gi%2) +: 8]
                         :        Write_data[8*gi +: 8];
      assign merged_word[8*gi +: 8] = lane_mask[gi] ? wr_lane[gi] : rd_lane[gi];
    end
  endgenerate

  // Lane enables. For halfwords only addr[1] matters, which also forces alignment.
  always_comb begin
    lane_mask = 4'b0000;
    if (is_b) begin
      lane_mask = 4'b0001 << byte_off;
    end else if (is_h) begin
      lane_mask = byte_off[1] ? 4'b1100 : 4'b0011;
    end else if (is_w) begin
      lane_mask = 4'b1111;
    end
  end

  // Load extraction and extension. Output is zero unless the load is legal and enabled.
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  assign byte_sel = rd_lane[byte_off];
  assign half_sel = byte_off[1] ? rd_word[31:16] : rd_word[15:0];

  // Select and extend the load result
  always_comb begin
    load_data = 32'h0;
    if (load_ok) begin
      unique case (1'b1)
        is_b:    load_data = {{24{byte_sel[7]}}, byte_sel};
        is_bu:   load_data = {24'h0, byte_sel};
        is_h:    load_data = {{16{half_sel[15]}}, half_sel};
        is_hu:   load_data = {16'h0, half_sel};
        is_w:    load_data = rd_word;
        default: load_data = 32'h0;
      endcase
    end
  end

  assign MemData_out = load_data;
  assign busy        = busy_reg;

  // Clear-sweep FSM: reset restarts the sweep from word 0; the last write releases busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= CLEAR;
      busy_reg    <= 1'b1;
      clr_idx_reg <= '0;
    end else begin
      case (state_reg)
        CLEAR: begin
          clr_idx_reg <= clr_idx_reg + 1'b1;
          if (clr_idx_reg == LAST_IDX) begin
            state_reg <= READY;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= READY;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // Single write port, shared by the sweep and by stores that passed qualification
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_reg == CLEAR) begin
        mem[clr_idx_reg] <= 32'h0;
      end else if (store_en) begin
        mem[word_idx] <= merged_word;
      end
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  // Sticky error: latches any reported access error once the memory is ready
  always_ff @(posedge clk) begin
    if (reset) begin
      err_sticky <= 1'b0;
    end else if (access_err && !busy_reg) begin
      err_sticky <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_data_memory_bytewise.sv
// tb_data_memory_bytewise
//   Scoreboard bench for data_memory_bytewise. Expected load data and error
//   flags are computed from a byte-wide reference model. Each expected result
//   is queued when an access is driven and popped when the output is sampled
//   at the falling edge.
module tb_data_memory_bytewise;

  localparam int DEPTH = 256;
  localparam int BYTES = DEPTH * 4;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [2:0]  funct3 = 3'b010;
  logic [31:0] read_address = 32'h0;
  logic [31:0] Write_data = 32'h0;
  logic [31:0] MemData_out;
  logic        busy;
  logic        access_err;
`ifdef DMEM_MISALIGN_TRAP_EN
  logic        err_sticky;
`endif

  data_memory_bytewise #(.DEPTH_WORDS(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .funct3       (funct3),
    .read_address (read_address),
    .Write_data   (Write_data),
    .MemData_out  (MemData_out),
    .busy         (busy),
    .access_err   (access_err)
`ifdef DMEM_MISALIGN_TRAP_EN
    ,
    .err_sticky   (err_sticky)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t       sb_q [$];
  logic [7:0] model_mem [BYTES];
  int         n_checks = 0;
  int         n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic exp_err(input logic rd, input logic wr, input logic [2:0] f3,
                                   input logic [31:0] a);
    logic acc;
    acc = rd | wr;
    return (acc && (f3 == 3 || f3 == 6 || f3 == 7))
         | (wr && (f3 == 4 || f3 == 5))
         | (acc && (f3 == 1 || f3 == 5) && a[0])
         | (acc && (f3 == 2) && (a[1:0] != 2'b00));
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [2:0] f3);
    int   a, hb, wb;
    logic mis;
    logic [7:0]  b;
    logic [15:0] h;
    a   = int'(addr) & (BYTES - 1);
    mis = ((f3 == 1 || f3 == 5) && addr[0]) || (f3 == 2 && addr[1:0] != 2'b00);
    if (f3 == 3 || f3 >= 6) return 32'h0;
    if (TRAP && mis) return 32'h0;
    hb = a & ~1;
    wb = a & ~3;
    b  = model_mem[a];
    h  = {model_mem[hb + 1], model_mem[hb]};
    case (f3)
      3'd0:    return {{24{b[7]}}, b};
      3'd4:    return {24'h0, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd5:    return {16'h0, h};
      default: return {model_mem[wb + 3], model_mem[wb + 2], model_mem[wb + 1], model_mem[wb]};
    endcase
  endfunction

  task automatic model_store(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] d);
    int a, base;
    a = int'(addr) & (BYTES - 1);
    if (f3 == 0) begin
      model_mem[a] = d[7:0];
    end else if (f3 == 1 && !(TRAP && addr[0])) begin
      base = a & ~1;
      model_mem[base]     = d[7:0];
      model_mem[base + 1] = d[15:8];
    end else if (f3 == 2 && !(TRAP && addr[1:0] != 2'b00)) begin
      base = a & ~3;
      for (int k = 0; k < 4; k++) model_mem[base + k] = d[8*k +: 8];
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < BYTES; k++) model_mem[k] = 8'h0;
  endtask

  // All access tasks start and end 1 time unit after a rising edge.
  task automatic load_op(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] exp);
    exp_t e;
    read_address = addr; funct3 = f3; MemRead = 1'b1; MemWrite = 1'b0;
    sb_q.push_back('{data: exp, err: exp_err(1'b1, 1'b0, f3, addr)});
    @(negedge clk);
    e = sb_q.pop_front();
    $display("LD  %-12s f3=%0d addr=0x%08h data=0x%08h err=%0b", tag, f3, addr, MemData_out, access_err);
    check({tag, "_data"}, MemData_out, e.data);
    check({tag, "_err"}, {31'h0, access_err}, {31'h0, e.err});
    @(posedge clk); #1;
    MemRead = 1'b0;
  endtask

  task automatic load_m(input string tag, input logic [31:0] addr, input logic [2:0] f3);
    load_op(tag, addr, f3, model_load(addr, f3));
  endtask

  task automatic store_op(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] d);
    exp_t e;
    read_address = addr; funct3 = f3; Write_data = d; MemWrite = 1'b1; MemRead = 1'b0;
    sb_q.push_back('{data: 32'h0, err: exp_err(1'b0, 1'b1, f3, addr)});
    @(negedge clk);
    e = sb_q.pop_front();
    $display("ST  %-12s f3=%0d addr=0x%08h wdata=0x%08h err=%0b", tag, f3, addr, d, access_err);
    check({tag, "_noread"}, MemData_out, e.data);
    check({tag, "_err"}, {31'h0, access_err}, {31'h0, e.err});
    @(posedge clk); #1;
    MemWrite = 1'b0;
    if (f3 <= 2) model_store(addr, f3, d);
  endtask

  // Counts rising edges until busy drops; optionally probes a load/store while busy.
  task automatic wait_sweep(input string tag, input bit probe);
    int cnt;
    cnt = 0;
    if (probe) begin
      read_address = 32'h41; funct3 = 3'b010; Write_data = 32'hDEADBEEF;
      MemRead = 1'b1; MemWrite = 1'b1;
    end
    while (busy === 1'b1 && cnt < 1000) begin
      @(posedge clk); #1;
      cnt++;
      if (probe && cnt == 50) begin
        #3;
        $display("BSY probe addr=0x%08h data=0x%08h err=%0b", read_address, MemData_out, access_err);
        check("busy_rd_zero", MemData_out, 32'h0);
        check("busy_err", {31'h0, access_err}, 32'h1);
      end
    end
    MemRead = 1'b0; MemWrite = 1'b0;
    $display("SWP %s edges=%0d", tag, cnt);
    check(tag, cnt, DEPTH);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] addr, wd;
    logic [2:0]  f3;
    logic [2:0]  ld_f3 [6];
    ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    model_clear();

    // Reset for one edge, then the sweep
    @(posedge clk); #1;
    reset = 1'b0;
    check("reset_busy", {31'h0, busy}, 32'h1);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("reset_sticky", {31'h0, err_sticky}, 32'h0);
`endif
    wait_sweep("sweep1", 1'b0);
    load_m("clr_w0", 32'h0, 3'd2);
    load_m("clr_wtop", 32'h3FC, 3'd2);
    load_m("clr_wmid", 32'h200, 3'd2);

    // Lane selection and extension
    store_op("sw10", 32'h10, 3'd2, 32'h80FF7F01);
    load_op("lb10", 32'h10, 3'd0, 32'h00000001);
    load_op("lb11", 32'h11, 3'd0, 32'h0000007F);
    load_op("lb12", 32'h12, 3'd0, 32'hFFFFFFFF);
    load_op("lbu12", 32'h12, 3'd4, 32'h000000FF);
    load_op("lb13", 32'h13, 3'd0, 32'hFFFFFF80);
    load_op("lh12", 32'h12, 3'd1, 32'hFFFF80FF);
    load_op("lhu12", 32'h12, 3'd5, 32'h000080FF);
    load_op("lh10", 32'h10, 3'd1, 32'h00007F01);
    load_op("lw10", 32'h10, 3'd2, 32'h80FF7F01);

    // Partial stores keep the other lanes
    store_op("sw20", 32'h20, 3'd2, 32'hAABBCCDD);
    store_op("sb22", 32'h22, 3'd0, 32'h00000011);
    store_op("sh20", 32'h20, 3'd1, 32'h00002233);
    load_op("lw20", 32'h20, 3'd2, 32'hAA112233);

    // Address wrap
    store_op("sw400", 32'h400, 3'd2, 32'h12345678);
    load_op("lw0wrap", 32'h0, 3'd2, 32'h12345678);

`ifdef DMEM_MISALIGN_TRAP_EN
    check("sticky_pre", {31'h0, err_sticky}, 32'h0);
`endif
    // Misaligned halfword store
    store_op("sh21", 32'h21, 3'd1, 32'h0000BEEF);
    load_op("lw20_mis", 32'h20, 3'd2, TRAP ? 32'hAA112233 : 32'hAA11BEEF);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("sticky_set", {31'h0, err_sticky}, 32'h1);
`endif
    load_m("lh21_mis", 32'h21, 3'd1);
    load_m("lw22_mis", 32'h22, 3'd2);
    load_m("ld_f3_011", 32'h20, 3'd3);
    load_m("ld_f3_111", 32'h20, 3'd7);
    store_op("st_f3_100", 32'h20, 3'd4, 32'h55555555);
    store_op("st_f3_110", 32'h20, 3'd6, 32'h66666666);
    load_m("lw20_keep", 32'h20, 3'd2);

    // Output is zero while MemRead is low, even on a populated word
    read_address = 32'h10; funct3 = 3'd2;
    @(negedge clk);
    check("noread_zero", MemData_out, 32'h0);
    @(posedge clk); #1;

    // Same-cycle read and write of one word: old data now, new data after the edge
    read_address = 32'h30; funct3 = 3'd2; Write_data = 32'hCAFEF00D;
    MemRead = 1'b1; MemWrite = 1'b1;
    sb_q.push_back('{data: model_load(32'h30, 3'd2), err: 1'b0});
    @(negedge clk);
    begin
      exp_t e;
      e = sb_q.pop_front();
      $display("RW  addr=0x00000030 wdata=0xcafef00d data=0x%08h", MemData_out);
      check("rw_old", MemData_out, e.data);
    end
    @(posedge clk); #1;
    MemWrite = 1'b0; MemRead = 1'b0;
    model_store(32'h30, 3'd2, 32'hCAFEF00D);
    load_op("rw_new", 32'h30, 3'd2, 32'hCAFEF00D);

    // Random mixed traffic against the byte model
    for (int i = 0; i < 40; i++) begin
      addr = 32'($urandom_range(0, 2047));
      if ($urandom_range(0, 1) == 0) begin
        f3 = 3'($urandom_range(0, 2));
        wd = $urandom;
        store_op("rnd_st", addr, f3, wd);
      end else begin
        f3 = ld_f3[$urandom_range(0, 5)];
        load_m("rnd_ld", addr, f3);
      end
    end

    // Reset part-way into a sweep; stores during busy must be ignored
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check("mid_busy", {31'h0, busy}, 32'h1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("restart_busy", {31'h0, busy}, 32'h1);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("sticky_clr", {31'h0, err_sticky}, 32'h0);
`endif
    wait_sweep("sweep2", 1'b1);
    model_clear();
`ifdef DMEM_MISALIGN_TRAP_EN
    check("sticky_busy", {31'h0, err_sticky}, 32'h0);
`endif
    load_m("busy_st_drop", 32'h40, 3'd2);
    load_m("clr2_w20", 32'h20, 3'd2);
    load_m("clr2_w10", 32'h10, 3'd2);

    check("sb_empty", sb_q.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
